sim_finish_controller: RTL and testbench
========================================

Name: sim_finish_controller

Overview:
- Synthesizable end-of-simulation sequencer that sits between the test-driver shell and the test harness.
- Sequences DUT reset release and runs a free-running cycle counter.
- Arbitrates pass/fail reports from N_SRC harness monitors and enforces a max-cycle timeout.
- Gates the waveform-dump window and raises one sticky finish request with a reason code after a drain period that lets in-flight printfs flush.

Parameters:
N_SRC, 4, number of pass/fail reporting sources (>=1)
CNT_W, 64, width of the cycle counter and config values
RESET_CYCLES, 8, cycles dut_reset stays high after reset deasserts (>=1)
DRAIN_CYCLES, 16, cycles between the winning event and finish_req (>=0)

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
cfg_max_cycles  in  CNT_W  timeout limit; 0 disables timeout; held stable after reset
cfg_dump_start  in  CNT_W  cycle at which dump_en rises; 0 = dump from reset
src_valid  in  N_SRC  one-cycle report strobe per source
src_fail  in  N_SRC  qualifies src_valid: 1 = fail, 0 = pass
dut_reset  out  1  reset to the DUT/harness
cycle_count  out  CNT_W  cycles since reset deasserted
dump_en  out  1  waveform dump window
finish_req  out  1  sticky end-of-test request
finish_fail  out  1  test outcome is failure (valid when finish_req=1)
finish_reason  out  2  0 none, 1 pass, 2 fail, 3 timeout
finish_src  out  max(1,clog2(N_SRC))  index of the winning source; 0 for timeout

Behaviour:
- States: HOLD, RUN, DRAIN, DONE. All outputs are registered.
- Reset values:
  - state=HOLD, cycle_count=0, dut_reset=1.
  - finish_req=0, finish_fail=0, finish_reason=0, finish_src=0.
  - dump_en=(cfg_dump_start==0); hold and drain counters=0.
- Reset mid-operation returns to these values on the next edge from any state.
- cycle_count:
  - Increments by 1 on every edge while reset=0, in all states including DONE.
  - Reads 1 in the first cycle after reset deasserts.
  - Saturates at all-ones and never wraps.
- HOLD:
  - dut_reset=1 and src_valid is ignored.
  - Transitions to RUN when the hold counter reaches RESET_CYCLES, i.e. dut_reset is high for exactly RESET_CYCLES post-reset cycles.
  - dut_reset falls on the same edge the state becomes RUN.
- RUN, per cycle:
  - timeout = (cfg_max_cycles!=0) && (cycle_count > cfg_max_cycles).
  - Event priority: any fail report > timeout > any pass report. Among equal class, the lowest index wins.
  - On an event: latch finish_reason, finish_src and finish_fail (1 for fail/timeout), then go to DRAIN, or straight to DONE if DRAIN_CYCLES=0.
  - Losing simultaneous reports are dropped.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, then goes to DONE.
  - All src_valid and timeout are ignored; latched reason is unchanged.
- DONE:
  - finish_req=1, sticky until reset. finish_reason, finish_src and finish_fail are held.
- finish_req rises exactly DRAIN_CYCLES+1 edges after the event cycle.
- finish_reason, finish_src and finish_fail are visible from the edge after the event; consumers qualify them with finish_req.
- dump_en:
  - Next value = (cfg_dump_start==0 || cycle_count+1 >= cfg_dump_start) && next_state!=DONE.
  - Consequently it rises in the cycle cycle_count equals cfg_dump_start and falls in the same cycle finish_req rises.
- dut_reset stays 0 in DRAIN and DONE; the DUT is not re-reset.
- Counter width rule: comparisons are unsigned CNT_W. Timeout is strictly greater-than, matching "count exceeds max".

Test Plan:
- Reset sequence: reset high 3 cycles, then low; RESET_CYCLES=8 -> dut_reset=1 while cycle_count 1..8, 0 from cycle_count=9; all finish outputs 0.
- Pass path: src_valid=4'b0100, src_fail=0 at cycle_count=20, DRAIN_CYCLES=16 -> finish_req rises at cycle_count=37; reason=1, src=2, fail=0; later src_valid ignored.
- Priority: same cycle src_valid=4'b1011, src_fail=4'b1010 with timeout also true -> reason=2, src=1, fail=1. Second case: only pass reports plus timeout -> reason=3, src=0.
- Timeout: cfg_max_cycles=50, no reports -> event at cycle_count=51, finish_req at 68, reason=3, fail=1. A second run with cfg_max_cycles=0 never finishes.
- Dump window: cfg_dump_start=30 -> dump_en=0 until cycle_count=30, 1 afterwards, 0 when finish_req rises. With cfg_dump_start=0 -> dump_en=1 during reset.
- Edge cases:
  - Reports during HOLD are ignored.
  - DRAIN_CYCLES=0: a report at cycle_count=15 gives finish_req at 16.
  - Reset asserted in DRAIN clears all outputs; a new run behaves like the first.

Source files
------------

// File: rtl/sim_finish_controller.sv
// End-of-simulation sequencer: DUT reset release, cycle counter,
// pass/fail/timeout arbitration, dump window and sticky finish request.
module sim_finish_controller #(
  parameter int N_SRC        = 4,
  parameter int CNT_W        = 64,
  parameter int RESET_CYCLES = 8,
  parameter int DRAIN_CYCLES = 16,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_max_cycles,
  input  logic [CNT_W-1:0] cfg_dump_start,
  input  logic [N_SRC-1:0] src_valid,
  input  logic [N_SRC-1:0] src_fail,
  output logic             dut_reset,
  output logic [CNT_W-1:0] cycle_count,
  output logic             dump_en,
  output logic             finish_req,
  output logic             finish_fail,
  output logic [1:0]       finish_reason,
  output logic [SW-1:0]    finish_src
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [HW-1:0] HLAST = HW'(RESET_CYCLES);
  localparam logic [DW-1:0] DLAST =
    DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [1:0] R_PASS = 2'd1;
  localparam logic [1:0] R_FAIL = 2'd2;
  localparam logic [1:0] R_TOUT = 2'd3;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [DW-1:0]    drain_cnt, drain_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout;
  logic             any_fail, any_pass;
  logic [SW-1:0]    fail_idx, pass_idx;
  logic             rst_nxt, req_nxt;
  logic             fail_nxt, dump_nxt;
  logic [1:0]       reason_nxt;
  logic [SW-1:0]    src_nxt;
  logic             ev;

  assign cnt_nxt = (&cycle_count) ? cycle_count
                                  : cycle_count + CNT_W'(1);

  assign timeout = (cfg_max_cycles != '0) &&
                   (cycle_count > cfg_max_cycles);

  // Descending scan so the lowest index is the last to write.
  always_comb begin
    any_fail = 1'b0;
    any_pass = 1'b0;
    fail_idx = '0;
    pass_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_valid[i] && src_fail[i]) begin
        any_fail = 1'b1;
        fail_idx = SW'(i);
      end
      if (src_valid[i] && !src_fail[i]) begin
        any_pass = 1'b1;
        pass_idx = SW'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    drain_nxt  = drain_cnt;
    reason_nxt = finish_reason;
    src_nxt    = finish_src;
    fail_nxt   = finish_fail;
    ev         = 1'b0;
    unique case (state)
      HOLD: begin
        if (hold_cnt == HLAST) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        if (any_fail) begin
          ev         = 1'b1;
          reason_nxt = R_FAIL;
          src_nxt    = fail_idx;
          fail_nxt   = 1'b1;
        end else if (timeout) begin
          ev         = 1'b1;
          reason_nxt = R_TOUT;
          src_nxt    = '0;
          fail_nxt   = 1'b1;
        end else if (any_pass) begin
          ev         = 1'b1;
          reason_nxt = R_PASS;
          src_nxt    = pass_idx;
          fail_nxt   = 1'b0;
        end
        if (ev) begin
          state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          drain_nxt = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt == DLAST) begin
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_cnt + DW'(1);
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
    rst_nxt  = (state_nxt == HOLD);
    req_nxt  = (state_nxt == DONE);
    dump_nxt = ((cfg_dump_start == '0) ||
                (cnt_nxt >= cfg_dump_start)) &&
               (state_nxt != DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      drain_cnt     <= '0;
      cycle_count   <= '0;
      dut_reset     <= 1'b1;
      dump_en       <= (cfg_dump_start == '0);
      finish_req    <= 1'b0;
      finish_fail   <= 1'b0;
      finish_reason <= 2'd0;
      finish_src    <= '0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      drain_cnt     <= drain_nxt;
      cycle_count   <= cnt_nxt;
      dut_reset     <= rst_nxt;
      dump_en       <= dump_nxt;
      finish_req    <= req_nxt;
      finish_fail   <= fail_nxt;
      finish_reason <= reason_nxt;
      finish_src    <= src_nxt;
    end
  end

endmodule

// File: tb/tb_sim_finish_controller.sv
// Directed bench for sim_finish_controller: reset, pass, priority,
// timeout, dump window, zero-drain and mid-drain reset.
module tb_sim_finish_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cfg_max_cycles;
  logic [63:0] cfg_dump_start;
  logic [3:0]  src_valid;
  logic [3:0]  src_fail;

  logic        dut_reset, dump_en, finish_req, finish_fail;
  logic [63:0] cycle_count;
  logic [1:0]  finish_reason, finish_src;

  logic        z_dut_reset, z_dump_en, z_finish_req, z_finish_fail;
  logic [63:0] z_cycle_count;
  logic [1:0]  z_finish_reason, z_finish_src;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sim_finish_controller dut (
    .clock(clock), .reset(reset),
    .cfg_max_cycles(cfg_max_cycles),
    .cfg_dump_start(cfg_dump_start),
    .src_valid(src_valid), .src_fail(src_fail),
    .dut_reset(dut_reset), .cycle_count(cycle_count),
    .dump_en(dump_en), .finish_req(finish_req),
    .finish_fail(finish_fail),
    .finish_reason(finish_reason),
    .finish_src(finish_src)
  );

  sim_finish_controller #(.DRAIN_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .cfg_max_cycles(cfg_max_cycles),
    .cfg_dump_start(cfg_dump_start),
    .src_valid(src_valid), .src_fail(src_fail),
    .dut_reset(z_dut_reset), .cycle_count(z_cycle_count),
    .dump_en(z_dump_en), .finish_req(z_finish_req),
    .finish_fail(z_finish_fail),
    .finish_reason(z_finish_reason),
    .finish_src(z_finish_src)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cnt(input int n);
    int b = 2000;
    while (cycle_count < 64'(n) && b > 0) begin
      step();
      b--;
    end
    chk("wait_cnt", cycle_count, 64'(n));
  endtask

  task automatic pulse(input logic [3:0] v, input logic [3:0] f);
    src_valid = v;
    src_fail  = f;
    step();
    src_valid = '0;
    src_fail  = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    src_valid = '0;
    src_fail  = '0;
    repeat (3) step();
    chk("rst_cnt", cycle_count, 0);
    chk("rst_dutrst", dut_reset, 1);
    chk("rst_req", finish_req, 0);
    chk("rst_fail", finish_fail, 0);
    chk("rst_reason", finish_reason, 0);
    chk("rst_src", finish_src, 0);
    chk("rst_dump", dump_en, cfg_dump_start == 0);
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset          = 1'b1;
    cfg_max_cycles = 0;
    cfg_dump_start = 30;
    src_valid      = '0;
    src_fail       = '0;

    // Reset sequence, HOLD-ignored report, pass path, dump window
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      chk("hold_cnt", cycle_count, 64'(c));
      chk("hold_dutrst", dut_reset, c <= 8);
      if (c == 3) begin
        src_valid = 4'b0001;
        src_fail  = 4'b0001;
      end else begin
        src_valid = '0;
        src_fail  = '0;
      end
      if (c < 9) step();
    end
    wait_cnt(10);
    chk("hold_ignored", finish_reason, 0);
    wait_cnt(20);
    pulse(4'b0100, 4'b0000);
    chk("pass_reason", finish_reason, 1);
    chk("pass_src", finish_src, 2);
    chk("pass_fail", finish_fail, 0);
    chk("pass_req_early", finish_req, 0);
    wait_cnt(29);
    chk("dump_29", dump_en, 0);
    step();
    chk("dump_30", dump_en, 1);
    wait_cnt(36);
    chk("pass_req_36", finish_req, 0);
    chk("dump_36", dump_en, 1);
    step();
    chk("pass_req_37", finish_req, 1);
    chk("dump_37", dump_en, 0);
    wait_cnt(40);
    pulse(4'b0001, 4'b0001);
    wait_cnt(45);
    chk("done_reason", finish_reason, 1);
    chk("done_req", finish_req, 1);
    chk("done_dutrst", dut_reset, 0);

    // Fail beats timeout beats pass
    cfg_max_cycles = 5;
    cfg_dump_start = 0;
    do_reset();
    chk("dump0_c1", dump_en, 1);
    wait_cnt(9);
    pulse(4'b1011, 4'b1010);
    chk("prio_reason", finish_reason, 2);
    chk("prio_src", finish_src, 1);
    chk("prio_fail", finish_fail, 1);
    chk("prio_dump", dump_en, 1);
    wait_cnt(25);
    chk("prio_req_25", finish_req, 0);
    step();
    chk("prio_req_26", finish_req, 1);
    chk("prio_dump_26", dump_en, 0);

    do_reset();
    wait_cnt(9);
    pulse(4'b0110, 4'b0000);
    chk("tpri_reason", finish_reason, 3);
    chk("tpri_src", finish_src, 0);
    chk("tpri_fail", finish_fail, 1);

    // Timeout only
    cfg_max_cycles = 50;
    do_reset();
    wait_cnt(51);
    chk("tout_51", finish_reason, 0);
    step();
    chk("tout_reason", finish_reason, 3);
    chk("tout_fail", finish_fail, 1);
    wait_cnt(67);
    chk("tout_req_67", finish_req, 0);
    step();
    chk("tout_req_68", finish_req, 1);

    // Timeout disabled
    cfg_max_cycles = 0;
    do_reset();
    wait_cnt(200);
    chk("notout_req", finish_req, 0);
    chk("notout_reason", finish_reason, 0);

    // Zero drain finishes on the edge after the event
    do_reset();
    wait_cnt(15);
    pulse(4'b0001, 4'b0000);
    chk("z_cnt", z_cycle_count, 16);
    chk("z_req", z_finish_req, 1);
    chk("z_reason", z_finish_reason, 1);
    chk("z_src", z_finish_src, 0);
    chk("z_dump", z_dump_en, 0);
    chk("z_main_req", finish_req, 0);
    wait_cnt(32);
    chk("z_main_req32", finish_req, 1);

    // Reset during DRAIN, then a fresh run
    cfg_dump_start = 30;
    do_reset();
    wait_cnt(20);
    pulse(4'b1000, 4'b0000);
    chk("mid_src", finish_src, 3);
    wait_cnt(25);
    do_reset();
    chk("rerun_c1", cycle_count, 1);
    chk("rerun_dutrst", dut_reset, 1);
    wait_cnt(20);
    pulse(4'b1000, 4'b0000);
    wait_cnt(36);
    chk("rerun_req36", finish_req, 0);
    step();
    chk("rerun_req37", finish_req, 1);
    chk("rerun_reason", finish_reason, 1);
    chk("rerun_src", finish_src, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
